// File: rtl/hazard_int_ctrl.sv
// Decode-stage sequencer: load-use stall, jump flush and interrupt entry (drain, push PC, vector).
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_int_ctrl #(
   parameter int REG_ADDR_W   = 3,
   parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_STATS_EN
   ,
   parameter int CNT_W        = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic                  dec_rs1_used,
   input  logic                  dec_rs2_used,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic                  idex_mem_read,
   input  logic                  idex_reg_write,
   input  logic                  jump_taken,
   input  logic                  interrupt_signal,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  int_push,
   output logic                  int_push_hi,
   output logic                  int_vector_load,
   output logic                  int_ack,
   output logic                  int_busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
`endif
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {S_RUN, S_DRAIN, S_PUSH_HI, S_PUSH_LO, S_VECTOR} state_t;

   state_t        state_reg;
   logic [CW-1:0] drain_cnt_reg;
   logic          int_pending_reg;
   logic          int_again_reg;

   logic load_hazard;
   logic pc_we_c, flush_c, bubble_c, push_c, push_hi_c, vload_c, ack_c, busy_c;

   assign load_hazard = idex_mem_read & idex_reg_write &
                        ((dec_rs1_used & (dec_rs1 == idex_rd)) |
                         (dec_rs2_used & (dec_rs2 == idex_rd)));

   always_comb begin
      pc_we_c   = 1'b0;
      flush_c   = 1'b0;
      bubble_c  = 1'b0;
      push_c    = 1'b0;
      push_hi_c = 1'b0;
      vload_c   = 1'b0;
      ack_c     = 1'b0;
      busy_c    = 1'b1;
      unique case (state_reg)
         S_RUN: begin
            busy_c = 1'b0;
            if (jump_taken) begin
               pc_we_c  = 1'b1;
               flush_c  = 1'b1;
               bubble_c = 1'b1;
            end else if (load_hazard) begin
               bubble_c = 1'b1;
            end else begin
               pc_we_c = 1'b1;
            end
         end
         // Jumps resolving during the drain still redirect the PC, so the pushed PC is the resume point.
         S_DRAIN: begin
            pc_we_c  = jump_taken;
            flush_c  = 1'b1;
            bubble_c = 1'b1;
         end
         S_PUSH_HI: begin
            push_c    = 1'b1;
            push_hi_c = 1'b1;
            bubble_c  = 1'b1;
         end
         S_PUSH_LO: begin
            push_c   = 1'b1;
            bubble_c = 1'b1;
         end
         S_VECTOR: begin
            vload_c = 1'b1;
            pc_we_c = 1'b1;
            ack_c   = 1'b1;
            flush_c = 1'b1;
         end
         default: busy_c = 1'b0;
      endcase
   end

   // IF/ID follows the PC: frozen together, loaded (or flushed) together.
   assign pc_write_en     = reset & pc_we_c;
   assign ifid_write_en   = reset & pc_we_c;
   assign ifid_flush      = reset & flush_c;
   assign idex_bubble     = reset & bubble_c;
   assign int_push        = reset & push_c;
   assign int_push_hi     = reset & push_hi_c;
   assign int_vector_load = reset & vload_c;
   assign int_ack         = reset & ack_c;
   assign int_busy        = reset & busy_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_RUN;
         drain_cnt_reg   <= '0;
         int_pending_reg <= 1'b0;
         int_again_reg   <= 1'b0;
      end else begin
         // A request seen while busy survives the acknowledge of the sequence in progress.
         int_pending_reg <= interrupt_signal | (ack_c ? int_again_reg : int_pending_reg);
         int_again_reg   <= ~ack_c & (int_again_reg | (busy_c & interrupt_signal));
         unique case (state_reg)
            S_RUN: begin
               if (int_pending_reg && !jump_taken && !load_hazard) begin
                  state_reg     <= S_DRAIN;
                  drain_cnt_reg <= '0;
               end
            end
            S_DRAIN: begin
               if (drain_cnt_reg == DRAIN_LAST) state_reg <= S_PUSH_HI;
               else drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
            S_PUSH_HI: state_reg <= S_PUSH_LO;
            S_PUSH_LO: state_reg <= S_VECTOR;
            S_VECTOR:  state_reg <= S_RUN;
            default:   state_reg <= S_RUN;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_count_reg;
   logic [CNT_W-1:0] flush_count_reg;
   logic             stall_c;

   assign stall_c = (state_reg == S_RUN) & ~jump_taken & load_hazard;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count_reg <= '0;
         flush_count_reg <= '0;
      end else begin
         if (stall_c && (stall_count_reg != '1)) stall_count_reg <= stall_count_reg + 1'b1;
         if (flush_c && (flush_count_reg != '1)) flush_count_reg <= flush_count_reg + 1'b1;
      end
   end

   assign stall_count = stall_count_reg;
   assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// Directed bench for hazard_int_ctrl: per-cycle expected output vectors go through a scoreboard queue.
// Statistics counters are checked when HAZARD_STATS_EN is defined.
module tb_hazard_int_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dec_rs1, dec_rs2, idex_rd;
   logic       dec_rs1_used, dec_rs2_used, idex_mem_read, idex_reg_write;
   logic       jump_taken, interrupt_signal;
   logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
   logic       int_push, int_push_hi, int_vector_load, int_ack, int_busy;
`ifdef HAZARD_STATS_EN
   logic [15:0] stall_count, flush_count;
`endif

   hazard_int_ctrl dut (
      .clk(clk), .reset(reset),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
      .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
      .jump_taken(jump_taken), .interrupt_signal(interrupt_signal),
      .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .int_push(int_push), .int_push_hi(int_push_hi),
      .int_vector_load(int_vector_load), .int_ack(int_ack), .int_busy(int_busy)
`ifdef HAZARD_STATS_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   always #5 clk = ~clk;

   // Vector order: pc_we, ifid_we, flush, bubble, push, push_hi, vload, ack, busy
   localparam logic [8:0] ZERO  = 9'b000000000;
   localparam logic [8:0] RUN_N = 9'b110000000;
   localparam logic [8:0] HAZ   = 9'b000100000;
   localparam logic [8:0] JMP   = 9'b111100000;
   localparam logic [8:0] DRN   = 9'b001100001;
   localparam logic [8:0] DRN_J = 9'b111100001;
   localparam logic [8:0] PHI   = 9'b000111001;
   localparam logic [8:0] PLO   = 9'b000110001;
   localparam logic [8:0] VEC   = 9'b111000111;

   logic [8:0] exp_q[$];
   int n_assert = 0;
   int n_fail   = 0;
   int stall_exp = 0;
   int flush_exp = 0;

   function automatic logic [8:0] observed();
      return {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, int_push,
              int_push_hi, int_vector_load, int_ack, int_busy};
   endfunction

   task automatic chk(input logic [8:0] e, input string tag);
      logic [8:0] obs;
      logic [8:0] want;
      exp_q.push_back(e);
      if (reset && e == HAZ) stall_exp++;
      if (reset && e[6]) flush_exp++;
      obs  = observed();
      want = exp_q.pop_front();
      n_assert++;
      assert (obs === want)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
      $display("step %-12s outputs=%b", tag, obs);
   endtask

   // One clock cycle: inputs already driven, compare on the falling edge, step past the rising edge.
   task automatic cyc(input logic [8:0] e, input string tag);
      @(negedge clk);
      chk(e, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_rs1 = 3'd0; dec_rs2 = 3'd0; idex_rd = 3'd0;
      dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
      idex_mem_read = 1'b0; idex_reg_write = 1'b0;
      jump_taken = 1'b0; interrupt_signal = 1'b0;
   endtask

   task automatic set_haz();
      idex_mem_read = 1'b1; idex_reg_write = 1'b1;
      idex_rd = 3'd3; dec_rs2 = 3'd3; dec_rs2_used = 1'b1;
   endtask

   task automatic irq_entry(input string tag);
      interrupt_signal = 1'b1;
      cyc(RUN_N, {tag, "_req"});
      interrupt_signal = 1'b0;
      cyc(RUN_N, {tag, "_acc"});
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #1;
      chk(ZERO, "rst_async");
      cyc(ZERO, "rst_hold");
      reset = 1'b1;
      cyc(RUN_N, "run");

      // Load-use via rs2 stalls for exactly the hazard cycle
      set_haz();
      cyc(HAZ, "haz_rs2");
      idle();
      cyc(RUN_N, "haz_gone");
      // Matching rs1 but unused, and load without register write: no stall
      idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 3'd5; dec_rs1 = 3'd5;
      cyc(RUN_N, "rs1_unused");
      dec_rs1_used = 1'b1; idex_reg_write = 1'b0;
      cyc(RUN_N, "no_regwr");
      idex_reg_write = 1'b1;
      cyc(HAZ, "haz_rs1");
      idle();
      // Jump wins over hazard
      set_haz(); jump_taken = 1'b1;
      cyc(JMP, "haz_jump");
      idle();
      cyc(RUN_N, "after_jump");

      // Pending request waits behind hazard and jump, then a full entry sequence
      interrupt_signal = 1'b1;
      cyc(RUN_N, "i1_req");
      interrupt_signal = 1'b0;
      set_haz();
      cyc(HAZ, "i1_haz_hold");
      idle(); jump_taken = 1'b1;
      cyc(JMP, "i1_jmp_hold");
      idle();
      cyc(RUN_N, "i1_acc");
      cyc(DRN, "i1_drain0");
      cyc(DRN, "i1_drain1");
      cyc(DRN, "i1_drain2");
      cyc(PHI, "i1_push_hi");
      cyc(PLO, "i1_push_lo");
      cyc(VEC, "i1_vector");
      cyc(RUN_N, "i1_run");
      cyc(RUN_N, "i1_idle");

      // Jump during the second drain cycle
      irq_entry("i2");
      cyc(DRN, "i2_drain0");
      jump_taken = 1'b1;
      cyc(DRN_J, "i2_drain1_j");
      jump_taken = 1'b0;
      cyc(DRN, "i2_drain2");
      cyc(PHI, "i2_push_hi");
      cyc(PLO, "i2_push_lo");
      cyc(VEC, "i2_vector");
      cyc(RUN_N, "i2_run");

      // Second request during PUSH_LO is serviced after one RUN cycle
      irq_entry("i3");
      cyc(DRN, "i3_drain0");
      cyc(DRN, "i3_drain1");
      cyc(DRN, "i3_drain2");
      cyc(PHI, "i3_push_hi");
      interrupt_signal = 1'b1;
      cyc(PLO, "i3_push_lo");
      interrupt_signal = 1'b0;
      cyc(VEC, "i3_vector");
      cyc(RUN_N, "i4_gap");
      cyc(DRN, "i4_drain0");
      cyc(DRN, "i4_drain1");
      cyc(DRN, "i4_drain2");
      cyc(PHI, "i4_push_hi");
      cyc(PLO, "i4_push_lo");
      cyc(VEC, "i4_vector");
      cyc(RUN_N, "i4_run");
      cyc(RUN_N, "i4_idle");

      // Reset in the middle of PUSH_HI
      irq_entry("i5");
      cyc(DRN, "i5_drain0");
      cyc(DRN, "i5_drain1");
      cyc(DRN, "i5_drain2");
      chk(PHI, "i5_push_hi");
      reset = 1'b0;
      stall_exp = 0;
      flush_exp = 0;
      #1;
      chk(ZERO, "i5_rst_async");
      cyc(ZERO, "i5_rst_hold");
      reset = 1'b1;
      cyc(RUN_N, "i5_no_pend0");
      cyc(RUN_N, "i5_no_pend1");
      cyc(RUN_N, "i5_no_pend2");

      // Five stall cycles for the statistics
      for (int i = 0; i < 5; i++) begin
         set_haz();
         cyc(HAZ, "stat_haz");
         idle();
         cyc(RUN_N, "stat_run");
      end
`ifdef HAZARD_STATS_EN
      @(negedge clk);
      n_assert++;
      assert (stall_count === 16'(stall_exp))
      else begin
         n_fail++;
         $error("FAIL stall_count: observed %0d expected %0d", stall_count, stall_exp);
      end
      n_assert++;
      assert (flush_count === 16'(flush_exp))
      else begin
         n_fail++;
         $error("FAIL flush_count: observed %0d expected %0d", flush_count, flush_exp);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
